// File: rtl/rv_plic_gateway_cnt.sv
// PLIC interrupt gateway: per-source level/edge mode, optional 2-flop input
// synchroniser, and a saturating per-source counter that queues edges.
module rv_plic_gateway_cnt #(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned SYNC_EN  = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] src,
  input  logic [N_SOURCE-1:0] le,
  input  logic [N_SOURCE-1:0] claim,
  input  logic [N_SOURCE-1:0] complete,
  input  logic [N_SOURCE-1:0] ovf_clr,
  output logic [N_SOURCE-1:0] ip,
  output logic [N_SOURCE-1:0] ia,
  output logic [N_SOURCE-1:0] ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_SOURCE-1:0] w_s;
  logic [N_SOURCE-1:0] r_src_d;
  logic [N_SOURCE-1:0] w_set;
  logic [N_SOURCE-1:0] w_launch;
  logic [N_SOURCE-1:0] w_sat;
  logic [N_SOURCE-1:0] r_ip;
  logic [N_SOURCE-1:0] r_ia;
  logic [N_SOURCE-1:0] r_ovf;
  logic [N_SOURCE-1:0] w_ip_nxt;
  logic [N_SOURCE-1:0] w_ia_nxt;
  logic [N_SOURCE-1:0] w_ovf_nxt;
  logic [CNT_W-1:0]    r_cnt     [N_SOURCE];
  logic [CNT_W-1:0]    w_cnt_nxt [N_SOURCE];

  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [N_SOURCE-1:0] r_sync1;
      logic [N_SOURCE-1:0] r_sync2;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_sync1 <= '0;
          r_sync2 <= '0;
        end else begin
          r_sync1 <= src;
          r_sync2 <= r_sync1;
        end
      end

      assign w_s = r_sync2;
    end else begin : g_nosync
      assign w_s = src;
    end
  endgenerate

  always_comb begin
    w_set     = '0;
    w_launch  = '0;
    w_sat     = '0;
    w_ip_nxt  = '0;
    w_ia_nxt  = '0;
    w_ovf_nxt = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_set[i]     = le[i] ? (w_s[i] & ~r_src_d[i]) : w_s[i];
      w_launch[i]  = ~r_ip[i] & ~r_ia[i] &
                     (w_set[i] | (le[i] & (r_cnt[i] != '0)));
      w_ip_nxt[i]  = (r_ip[i] | w_launch[i]) & ~claim[i];
      w_ia_nxt[i]  = (r_ia[i] | w_launch[i]) & ~complete[i];

      // A new edge that launches directly is consumed without touching cnt.
      if (!le[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (w_set[i] && !w_launch[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_sat[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end else if (!w_set[i] && w_launch[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
      end

      w_ovf_nxt[i] = ovf_clr[i] ? 1'b0 : (r_ovf[i] | w_sat[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_src_d <= '0;
      r_ip    <= '0;
      r_ia    <= '0;
      r_ovf   <= '0;
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_src_d <= w_s;
      r_ip    <= w_ip_nxt;
      r_ia    <= w_ia_nxt;
      r_ovf   <= w_ovf_nxt;
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign ip  = r_ip;
  assign ia  = r_ia;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_rv_plic_gateway_cnt.sv
// Scoreboard bench: two gateways (no sync / 2-flop sync, CNT_W=2) driven with
// identical directed+random stimulus and checked against a per-source model.
module tb_rv_plic_gateway_cnt;

  localparam int N   = 8;
  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] src, le, claim, complete, ovf_clr;
  logic [N-1:0] ip0, ia0, ovf0, ip1, ia1, ovf1;

  typedef struct packed {
    logic [N-1:0] ip;
    logic [N-1:0] ia;
    logic [N-1:0] ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: [0] = unsynchronised gateway, [1] = synchronised one.
  bit m_ip   [2][N];
  bit m_ia   [2][N];
  bit m_ovf  [2][N];
  bit m_prev [2][N];
  int m_cnt  [2][N];
  bit m_sy1  [N];
  bit m_sy2  [N];

  rv_plic_gateway_cnt #(.N_SOURCE(N), .CNT_W(CW), .SYNC_EN(0)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .src(src), .le(le), .claim(claim),
    .complete(complete), .ovf_clr(ovf_clr), .ip(ip0), .ia(ia0), .ovf(ovf0)
  );

  rv_plic_gateway_cnt #(.N_SOURCE(N), .CNT_W(CW), .SYNC_EN(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .src(src), .le(le), .claim(claim),
    .complete(complete), .ovf_clr(ovf_clr), .ip(ip1), .ia(ia1), .ovf(ovf1)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        m_ip[d][i] = 0; m_ia[d][i] = 0; m_ovf[d][i] = 0;
        m_prev[d][i] = 0; m_cnt[d][i] = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_sy1[i] = 0; m_sy2[i] = 0;
    end
  endtask

  // One clock edge of the reference: queued edges tracked as a plain count.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        bit s, set, go, lost;
        int n;
        s    = (d == 0) ? src[i] : m_sy2[i];
        set  = le[i] ? (s && !m_prev[d][i]) : s;
        go   = !m_ip[d][i] && !m_ia[d][i] && (set || (le[i] && m_cnt[d][i] > 0));
        lost = 0;
        if (!le[i]) begin
          m_cnt[d][i] = 0;
        end else begin
          n = m_cnt[d][i] + int'(set) - int'(go);
          if (n > MAX) begin
            n    = MAX;
            lost = 1;
          end
          m_cnt[d][i] = n;
        end
        m_ip[d][i]   = (m_ip[d][i] || go) && !claim[i];
        m_ia[d][i]   = (m_ia[d][i] || go) && !complete[i];
        m_ovf[d][i]  = ovf_clr[i] ? 1'b0 : (m_ovf[d][i] || lost);
        m_prev[d][i] = s;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_sy2[i] = m_sy1[i];
      m_sy1[i] = src[i];
    end
  endtask

  function automatic exp_t model_out(int d);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.ip[i]  = m_ip[d][i];
      e.ia[i]  = m_ia[d][i];
      e.ovf[i] = m_ovf[d][i];
    end
    return e;
  endfunction

  task automatic push_exp();
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
    if (rst_i) model_reset();
    else       model_step();
    push_exp();
  endtask

  task automatic cycles(int k);
    for (int j = 0; j < k; j++) cycle();
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must already be 0 at the
  // next negedge, so the pending expectation for this cycle is replaced.
  task automatic do_reset();
    #1;
    rst_i = 1'b1;
    void'(q0.pop_back());
    void'(q1.pop_back());
    model_reset();
    push_exp();
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic check(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (q0.size() > 0 && q1.size() > 0) begin
      exp_t e0, e1;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check("ip_nosync",  ip0,  e0.ip);
      check("ia_nosync",  ia0,  e0.ia);
      check("ovf_nosync", ovf0, e0.ovf);
      check("ip_sync",    ip1,  e1.ip);
      check("ia_sync",    ia1,  e1.ia);
      check("ovf_sync",   ovf1, e1.ovf);
    end
  end

  task automatic clear_strobes();
    claim = '0; complete = '0; ovf_clr = '0;
  endtask

  task automatic random_phase(int ncyc, int p_cmp, int p_clr, int p_le, int p_rst);
    for (int c = 0; c < ncyc; c++) begin
      if ($urandom_range(99) < p_le) le = N'($urandom);
      src      = src ^ (N'($urandom) & N'($urandom));
      claim    = ($urandom_range(99) < 40)    ? (N'(1) << $urandom_range(N-1)) : '0;
      complete = ($urandom_range(99) < p_cmp) ? (N'(1) << $urandom_range(N-1)) : '0;
      ovf_clr  = ($urandom_range(99) < p_clr) ? N'($urandom) : '0;
      cycle();
      if ($urandom_range(999) < p_rst) do_reset();
    end
    clear_strobes();
  endtask

  initial begin
    rst_i = 1'b1;
    src = '0; le = '0;
    clear_strobes();
    model_reset();
    cycles(2);
    rst_i = 1'b0;
    cycles(2);

    // Level source held high through claim and complete.
    src[3] = 1'b1;
    cycles(4);
    claim = 8'h08;    cycle(); claim = '0;    cycles(2);
    complete = 8'h08; cycle(); complete = '0; cycles(4);
    src[3] = 1'b0;
    cycles(4);

    // Edge queueing: four pulses, then four claim+complete pairs.
    le = 8'h20;
    for (int k = 0; k < 4; k++) begin
      src[5] = 1'b1; cycle();
      src[5] = 1'b0; cycle();
    end
    cycles(4);
    for (int k = 0; k < 4; k++) begin
      claim = 8'h20; complete = 8'h20; cycle();
      clear_strobes(); cycles(2);
    end
    cycles(4);

    // Saturation on source 5, then clear, then clear racing a saturating edge.
    for (int k = 0; k < 7; k++) begin
      src[5] = 1'b1; cycle();
      src[5] = 1'b0; cycle();
    end
    cycles(3);
    ovf_clr = 8'h20; cycle(); ovf_clr = '0; cycles(2);
    src[5] = 1'b1; ovf_clr = 8'h20; cycle(); ovf_clr = '0; src[5] = 1'b0;
    cycles(2);
    src[5] = 1'b1; cycle(); src[5] = 1'b0; cycle();
    ovf_clr = 8'h20; cycles(4); ovf_clr = '0;

    // Mode switch to level discards queued edges.
    le = 8'h00; cycles(3);
    claim = 8'h20; complete = 8'h20; cycle(); clear_strobes();
    cycles(4);

    // Complete coinciding with a new edge on source 7.
    le = 8'h80;
    src[7] = 1'b1; cycle(); src[7] = 1'b0; cycles(4);
    complete = 8'h80; src[7] = 1'b1; cycle(); complete = '0; src[7] = 1'b0;
    cycles(4);
    claim = 8'h80; complete = 8'h80; cycle(); clear_strobes();
    cycles(4);

    // Reset while several sources are busy, then a normal first edge.
    le = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      src = 8'hFF; cycle();
      src = 8'h00; cycle();
    end
    do_reset();
    src = 8'h04; cycles(5); src = 8'h00; cycles(2);

    random_phase(400, 30, 10, 10, 10);
    random_phase(300, 5, 5, 2, 5);
    random_phase(300, 50, 20, 30, 10);

    src = '0; le = '0;
    clear_strobes();
    cycles(4);
    @(negedge clk_i);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv_plic_gateway_cnt.md
Name: rv_plic_gateway_cnt

Overview:
Next-generation PLIC interrupt gateway with per-source level/edge mode and an optional input synchroniser. Edge-triggered sources get a saturating per-source counter, so edges arriving while a request is pending or in service are queued, not dropped. It sits between raw interrupt sources and the PLIC priority/target logic, and drives per-source ip/ia vectors.

Parameters:
N_SOURCE, 32, number of interrupt sources (>=1)
CNT_W, 4, width of per-source edge counter (>=1); max queued edges = 2^CNT_W-1
SYNC_EN, 1, 1: 2-flop synchroniser on src; 0: src used directly (must be synchronous to clk_i)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
src  input  N_SOURCE  raw interrupt source lines
le  input  N_SOURCE  per-source mode: 0 level, 1 rising edge
claim  input  N_SOURCE  claim strobe, onehot0
complete  input  N_SOURCE  completion strobe, onehot0
ovf_clr  input  N_SOURCE  clears the ovf sticky bit, per source
ip  output  N_SOURCE  interrupt pending
ia  output  N_SOURCE  interrupt active (launched, not yet completed)
ovf  output  N_SOURCE  sticky: an edge was lost at counter saturation

Behaviour:
- Reset: sync flops, src_d, cnt, ip, ia, ovf all 0. Reset is async assert and takes effect mid-operation; queued edges are discarded.
- s = synchronised src (SYNC_EN=1, 2 flops) or src (SYNC_EN=0). src_d <= s each cycle.
- set[i] = le[i] ? (s[i] & ~src_d[i]) : s[i].
- launch[i] = ~ip[i] & ~ia[i] & (set[i] | (le[i] & cnt[i]!=0)).
- ip[i] next = (ip[i] | launch[i]) & ~claim[i].
- ia[i] next = (ia[i] | launch[i]) & ~complete[i].
- cnt, edge mode (le[i]=1):
  - set & launch: hold (the new edge is consumed directly).
  - ~set & launch: decrement.
  - set & ~launch: increment; at 2^CNT_W-1 hold and set ovf[i].
  - otherwise hold.
- cnt, level mode (le[i]=0): cnt forced to 0 next cycle, so a mode switch to level discards queued edges. ovf is not affected.
- ovf[i] next = ovf_clr[i] ? 0 : (ovf[i] | saturating edge). If clear and overflow occur in the same cycle, clear wins.
- Latency from the src rising edge to ip=1, with the source idle: 1 cycle if SYNC_EN=0, 3 cycles if SYNC_EN=1.
- claim with ip=0 has no effect. complete with ia=0 has no effect.
- claim and complete in the same cycle on the same source: both ip and ia clear. If cnt>0, launch occurs the following cycle.
- complete and a new edge in the same cycle: the edge increments cnt (ia still 1). Launch occurs the next cycle and decrements cnt. No edge is lost.
- Level mode: while ia=1, src is ignored. After complete, if src is still high, ip re-asserts 1 cycle after ia drops.
- ip is never set while ia=1, so at most one outstanding request per source.
- Sources are fully independent; there is no cross-source interaction.

Test Plan:
- Level, SYNC_EN=0: src[3]=1 held -> ip[3]=ia[3]=1 after 1 cycle; claim[3] -> ip[3]=0; complete[3] with src still 1 -> ip[3]=1 one cycle after ia[3] drops.
- Edge queueing: le[5]=1, 4 single-cycle pulses on src[5] separated by idle cycles, before any claim -> one ip, cnt=3. Then 4 claim+complete pairs -> 4 distinct ip assertions, final cnt=0 and ip=0.
- Saturation, CNT_W=2: 6 edges while ia=1 -> cnt=3, ovf=1. Then ovf_clr -> ovf=0. The same-cycle ovf_clr+saturating edge case -> ovf=0.
- Simultaneous complete+edge on source 7 -> ip[7] re-asserts one cycle after ia drops, cnt returns to 0, nothing lost.
- Synchroniser, SYNC_EN=1: src rise -> ip after exactly 3 cycles. Mode switch le[2] 1->0 with cnt=2 -> cnt=0 next cycle.
- Reset mid-operation: rst_i pulse while ip/ia/cnt/ovf are nonzero on several sources -> all outputs 0 immediately (async). The first edge after release behaves normally.
